// File: rtl/keypad_scan_ctrl_if.sv
// Key readout bus between keypad_scan_ctrl and the CPU side.
// master = controller, slave = bus reader.
interface keypad_scan_ctrl_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_ovf;
  logic       key_irq;

  modport master (
    output key_code,
    output key_valid,
    output key_ovf,
    output key_irq,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_ovf,
    input  key_irq,
    output key_ack
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column scan, debounce, hold-until-release.
// Define KEYPAD_SCAN_IRQ_EN to generate a key_irq pulse per accepted key.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 100000
) (
  input  logic         sys_clk_100M,
  input  logic         sys_rst_n,
  input  logic [3:0]   btn_key_row,
  output logic [3:0]   btn_key_col,
  keypad_scan_ctrl_if.master kbus
);

  localparam logic [15:0] DIV_LAST =
    16'(SCAN_DIV - 1);
  localparam logic [19:0] DB_LAST =
    20'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  sync_q, rs;
  logic [15:0] div_q, div_d;
  logic [19:0] db_q, db_d;
  logic [3:0]  col_q, col_d;
  logic [1:0]  cidx_q, cidx_d;
  logic [3:0]  pat_q, pat_d;
  logic [3:0]  col_nx;
  logic [1:0]  cidx_nx;
  logic [1:0]  row_idx;
  logic        accept;
  logic [3:0]  code_q;
  logic        valid_q;
  logic        ovf_q;

  always_ff @(posedge sys_clk_100M) begin
    if (!sys_rst_n) begin
      sync_q <= 4'hF;
      rs     <= 4'hF;
    end else begin
      sync_q <= btn_key_row;
      rs     <= sync_q;
    end
  end

  assign col_nx  = {col_q[2:0], col_q[3]};
  assign cidx_nx = (cidx_q == 2'd3) ? 2'd0
                                     : cidx_q + 2'd1;

  // Lowest-index pressed row wins.
  always_comb begin
    row_idx = 2'd0;
    priority case (1'b1)
      !pat_q[0]: row_idx = 2'd0;
      !pat_q[1]: row_idx = 2'd1;
      !pat_q[2]: row_idx = 2'd2;
      !pat_q[3]: row_idx = 2'd3;
      default:   row_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    db_d    = db_q;
    col_d   = col_q;
    cidx_d  = cidx_q;
    pat_d   = pat_q;
    accept  = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (rs != 4'hF) begin
            pat_d   = rs;
            db_d    = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d  = col_nx;
            cidx_d = cidx_nx;
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      DEBOUNCE: begin
        if (rs != pat_q) begin
          state_d = SCAN;
          db_d    = '0;
          div_d   = '0;
          col_d   = col_nx;
          cidx_d  = cidx_nx;
        end else if (db_q == DB_LAST) begin
          accept  = 1'b1;
          db_d    = '0;
          state_d = HOLD;
        end else begin
          db_d = db_q + 20'd1;
        end
      end
      HOLD: begin
        if (rs != 4'hF) begin
          db_d = '0;
        end else if (db_q == DB_LAST) begin
          db_d    = '0;
          div_d   = '0;
          state_d = SCAN;
          col_d   = col_nx;
          cidx_d  = cidx_nx;
        end else begin
          db_d = db_q + 20'd1;
        end
      end
      default: begin
        state_d = SCAN;
        db_d    = '0;
        div_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk_100M) begin
    if (!sys_rst_n) begin
      state_q <= SCAN;
      div_q   <= '0;
      db_q    <= '0;
      col_q   <= 4'b1110;
      cidx_q  <= 2'd0;
      pat_q   <= 4'hF;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      db_q    <= db_d;
      col_q   <= col_d;
      cidx_q  <= cidx_d;
      pat_q   <= pat_d;
    end
  end

  // An ack in the acceptance cycle lets the new key replace the old cleanly.
  always_ff @(posedge sys_clk_100M) begin
    if (!sys_rst_n) begin
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      code_q  <= {row_idx, cidx_q};
      valid_q <= 1'b1;
      ovf_q   <= valid_q & ~kbus.key_ack;
    end else if (kbus.key_ack && valid_q) begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end
  end

  assign btn_key_col    = col_q;
  assign kbus.key_code  = code_q;
  assign kbus.key_valid = valid_q;
  assign kbus.key_ovf   = ovf_q;

`ifdef KEYPAD_SCAN_IRQ_EN
  logic irq_q;

  always_ff @(posedge sys_clk_100M) begin
    if (!sys_rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= accept;
    end
  end

  assign kbus.key_irq = irq_q;
`else
  assign kbus.key_irq = 1'b0;
`endif

endmodule
